// File: rtl/dut_adc_multi.sv
// dut_adc_multi: SPI-slave front end of an emulated multi-channel ADC.
//
// Commands of W bits arrive MSB first on `in` while `en` is high and are
// sampled on rising `sclk` edges. Each word is classified as conversion,
// setup or averaging and latched into the matching register. An accepted
// conversion captures the selected channel sample and shifts it out on
// `miso` (MSB first) during the following sclk cycles.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   sclk, en, in      SPI clock, frame enable, MOSI (all asynchronous)
//   samples           NCH packed DW-bit channel samples (ch k at [k*DW +: DW])
//   miso              serial sample data to the master
//   setup/aver/conver last accepted command of each class
//   cmd_valid         one-clk pulse per accepted command
//   cmd_type          0 none, 1 setup, 2 averaging, 3 conversion
//   sel_ch            channel of the last accepted conversion
//   err               one-clk pulse per rejected conversion
module dut_adc_multi #(
    parameter int W   = 8,
    parameter int NCH = 4,
    parameter int DW  = 12,
    localparam int CHW = $clog2(NCH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              en,
    input  logic              in,
    input  logic [NCH*DW-1:0] samples,
    output logic              miso,
    output logic [W-1:0]      setup,
    output logic [W-1:0]      aver,
    output logic [W-1:0]      conver,
    output logic              cmd_valid,
    output logic [1:0]        cmd_type,
    output logic [CHW-1:0]    sel_ch,
    output logic              err
);

    localparam int BCW = (W > 1) ? $clog2(W) : 1;
    localparam int TCW = $clog2(DW + 1);

    localparam logic [1:0] CT_NONE  = 2'd0;
    localparam logic [1:0] CT_SETUP = 2'd1;
    localparam logic [1:0] CT_AVER  = 2'd2;
    localparam logic [1:0] CT_CONV  = 2'd3;

    logic           sclk_m, sclk_s, sclk_d;
    logic           en_m, en_s;
    logic           in_m, in_s;
    logic [W-1:0]   shreg;
    logic [BCW-1:0] bitcnt;
    logic           word_rdy;
    logic [DW-1:0]  tx;
    logic [TCW-1:0] tx_left;
    logic           primed;

    logic           rise, fall;
    logic           is_conv, is_setup, is_aver, ch_ok;
    logic [CHW-1:0] ch_field;

    assign rise = en_s &  sclk_s & ~sclk_d;
    assign fall = en_s & ~sclk_s &  sclk_d;

    // Channel field sits just below bit W-2; zero-pad when W is too narrow.
    if (W - 2 >= CHW) begin : g_fld
        assign ch_field = shreg[W-3 -: CHW];
    end else begin : g_fld_pad
        assign ch_field = {shreg[W-3:0], {(CHW-W+2){1'b0}}};
    end

    always_comb begin
        is_conv  = shreg[W-1];
        is_setup = (shreg[W-1 -: 2] == 2'b01);
        is_aver  = (shreg[W-1 -: 3] == 3'b001);
        ch_ok    = ({1'b0, ch_field} < (CHW+1)'(NCH));
    end

    assign miso = (tx_left != '0) ? tx[DW-1] : 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_m    <= 1'b0;
            sclk_s    <= 1'b0;
            sclk_d    <= 1'b0;
            en_m      <= 1'b0;
            en_s      <= 1'b0;
            in_m      <= 1'b0;
            in_s      <= 1'b0;
            shreg     <= '0;
            bitcnt    <= '0;
            word_rdy  <= 1'b0;
            tx        <= '0;
            tx_left   <= '0;
            primed    <= 1'b0;
            setup     <= '0;
            aver      <= '0;
            conver    <= '0;
            cmd_type  <= CT_NONE;
            sel_ch    <= '0;
            cmd_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            sclk_m    <= sclk;
            sclk_s    <= sclk_m;
            sclk_d    <= sclk_s;
            en_m      <= en;
            en_s      <= en_m;
            in_m      <= in;
            in_s      <= in_m;
            cmd_valid <= 1'b0;
            err       <= 1'b0;
            word_rdy  <= 1'b0;

            if (!en_s) begin
                bitcnt  <= '0;
                tx_left <= '0;
            end else begin
                if (rise) begin
                    shreg  <= {shreg[W-2:0], in_s};
                    primed <= 1'b1;
                    if (bitcnt == BCW'(W - 1)) begin
                        bitcnt   <= '0;
                        word_rdy <= 1'b1;
                    end else begin
                        bitcnt <= bitcnt + 1'b1;
                    end
                end
                // The fall that trails the command's last rise must not
                // consume the MSB; shifting starts only after the master
                // has had a rise to sample it.
                if (fall && primed && tx_left != '0) begin
                    tx      <= {tx[DW-2:0], 1'b0};
                    tx_left <= tx_left - 1'b1;
                end
            end

            if (word_rdy) begin
                if (is_conv) begin
                    if (ch_ok) begin
                        conver    <= shreg;
                        sel_ch    <= ch_field;
                        cmd_type  <= CT_CONV;
                        cmd_valid <= 1'b1;
                        tx        <= samples[int'(ch_field)*DW +: DW];
                        tx_left   <= TCW'(DW);
                        primed    <= 1'b0;
                    end else begin
                        err <= 1'b1;
                    end
                end else if (is_setup) begin
                    setup     <= shreg;
                    cmd_type  <= CT_SETUP;
                    cmd_valid <= 1'b1;
                end else if (is_aver) begin
                    aver      <= shreg;
                    cmd_type  <= CT_AVER;
                    cmd_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_dut_adc_multi.sv
// Randomised scoreboard bench for dut_adc_multi (W=8, NCH=3, DW=12).
// The driver acts as an SPI master; each complete command is run through a
// command-level reference model whose expected event is queued. A monitor
// pops one event per cmd_valid/err pulse and compares the DUT registers.
module tb_dut_adc_multi;

    localparam int W    = 8;
    localparam int NCH  = 3;
    localparam int DW   = 12;
    localparam int CHW  = 2;
    localparam time HALF = 50ns;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              sclk = 1'b0;
    logic              en = 1'b0;
    logic              in = 1'b0;
    logic [NCH*DW-1:0] samples;
    logic              miso;
    logic [W-1:0]      setup, aver, conver;
    logic              cmd_valid;
    logic [1:0]        cmd_type;
    logic [CHW-1:0]    sel_ch;
    logic              err;

    logic [DW-1:0] smp [NCH];

    always #5 clk = ~clk;

    always_comb begin
        samples = '0;
        for (int k = 0; k < NCH; k++) samples[k*DW +: DW] = smp[k];
    end

    dut_adc_multi #(.W(W), .NCH(NCH), .DW(DW)) u_dut (
        .clk(clk), .rst(rst), .sclk(sclk), .en(en), .in(in),
        .samples(samples), .miso(miso), .setup(setup), .aver(aver),
        .conver(conver), .cmd_valid(cmd_valid), .cmd_type(cmd_type),
        .sel_ch(sel_ch), .err(err)
    );

    typedef struct {
        bit         is_err;
        logic [1:0] ctype;
        logic [7:0] setup, aver, conver;
        logic [1:0] sel;
    } ev_t;

    ev_t q[$];
    int  checks = 0;
    int  failures = 0;

    // command-level reference state
    logic [7:0]    m_setup, m_aver, m_conver;
    logic [1:0]    m_type, m_sel;
    logic [DW-1:0] m_tx;
    bit            m_conv_ok;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_setup = 0; m_aver = 0; m_conver = 0; m_type = 0; m_sel = 0;
        m_conv_ok = 0;
    endtask

    task automatic push(input bit is_err);
        ev_t e;
        e.is_err = is_err; e.ctype = m_type; e.setup = m_setup;
        e.aver = m_aver; e.conver = m_conver; e.sel = m_sel;
        q.push_back(e);
    endtask

    task automatic model_word(input logic [7:0] w);
        int ch;
        m_conv_ok = 0;
        if (w >= 8'h80) begin
            ch = (int'(w) / 16) % 4;
            if (ch < NCH) begin
                m_conver = w; m_sel = 2'(ch); m_type = 3;
                m_tx = smp[ch]; m_conv_ok = 1;
                push(0);
            end else begin
                push(1);
            end
        end else if (w >= 8'h40) begin
            m_setup = w; m_type = 1; push(0);
        end else if (w >= 8'h20) begin
            m_aver = w; m_type = 2; push(0);
        end
    endtask

    // one SPI bit: present data, master samples miso, then rising/falling sclk
    task automatic bit_cycle(input logic b, output logic s);
        in = b;
        #(HALF);
        s = miso;
        sclk = 1'b1;
        #(HALF);
        sclk = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] w, input int nbits);
        logic s;
        for (int i = 0; i < nbits; i++) begin
            if (nbits == W && i == W - 1) model_word(w);
            bit_cycle(w[W-1-i], s);
        end
    endtask

    task automatic read_tx(input bit disturb);
        logic s;
        logic [DW-1:0] exp_v;
        exp_v = m_tx;
        for (int i = DW - 1; i >= 0; i--) begin
            bit_cycle(1'b0, s);
            chk("miso_bit", {31'd0, s}, {31'd0, exp_v[i]});
            if (disturb && i == DW - 3) smp[m_sel] = DW'($urandom);
        end
        bit_cycle(1'b0, s);
        chk("miso_after_tx", {31'd0, s}, 32'd0);
    endtask

    task automatic en_gap();
        en = 1'b0;
        repeat (6) @(negedge clk);
        chk("miso_idle", {31'd0, miso}, 32'd0);
        en = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_setup"},  32'(setup),     32'd0);
        chk({tag, "_aver"},   32'(aver),      32'd0);
        chk({tag, "_conver"}, 32'(conver),    32'd0);
        chk({tag, "_type"},   32'(cmd_type),  32'd0);
        chk({tag, "_sel"},    32'(sel_ch),    32'd0);
        chk({tag, "_miso"},   32'(miso),      32'd0);
        chk({tag, "_valid"},  32'(cmd_valid), 32'd0);
        chk({tag, "_err"},    32'(err),       32'd0);
    endtask

    // monitor: one queued event per observed pulse
    always @(negedge clk) begin
        if (!rst && (cmd_valid || err)) begin
            if (q.size() == 0) begin
                chk("unexpected_pulse", {30'd0, cmd_valid, err}, 32'd0);
            end else begin
                ev_t e;
                e = q.pop_front();
                chk("pulse_err",   32'(err),       32'(e.is_err));
                chk("pulse_valid", 32'(cmd_valid), 32'(!e.is_err));
                chk("cmd_type",    32'(cmd_type),  32'(e.ctype));
                chk("setup",       32'(setup),     32'(e.setup));
                chk("aver",        32'(aver),      32'(e.aver));
                chk("conver",      32'(conver),    32'(e.conver));
                chk("sel_ch",      32'(sel_ch),    32'(e.sel));
            end
        end
    end

    initial begin
        #10ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin
        logic [7:0] w;
        for (int k = 0; k < NCH; k++) smp[k] = DW'(12'h111 * (k + 1));
        model_reset();
        repeat (4) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("post_reset");

        en = 1'b1;
        repeat (4) @(negedge clk);
        send_frame(8'h45, W);
        send_frame(8'h2A, W);
        send_frame(8'h01, W);
        en_gap();

        smp[2] = 12'hABC;
        send_frame(8'hA0, W);
        read_tx(1);
        en_gap();

        send_frame(8'hB0, W);
        en_gap();

        send_frame(8'hB5, 5);
        en_gap();
        send_frame(8'h47, W);
        en_gap();

        // reset in the middle of a frame
        send_frame(8'hC5, 4);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_all_zero("midframe_reset");
        rst = 1'b0;
        model_reset();
        chk("queue_after_reset", 32'(q.size()), 32'd0);
        repeat (4) @(negedge clk);
        smp[0] = 12'h5E3;
        send_frame(8'h81, W);
        read_tx(0);
        en_gap();

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 3))
                0: w = 8'h80 | 8'($urandom_range(0, 127));
                1: w = 8'h40 | 8'($urandom_range(0, 63));
                2: w = 8'h20 | 8'($urandom_range(0, 31));
                default: w = 8'($urandom_range(0, 31));
            endcase
            for (int k = 0; k < NCH; k++) smp[k] = DW'($urandom);
            send_frame(w, W);
            if (m_conv_ok && $urandom_range(0, 1) == 1) begin
                read_tx($urandom_range(0, 1) == 1);
                en_gap();
            end else if ($urandom_range(0, 3) == 0) begin
                en_gap();
            end
        end

        en = 1'b0;
        repeat (20) @(negedge clk);
        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
